// File: rtl/smi_tx_ctrl.sv
// Purpose : SMI write-side controller; packs four strobed host bytes into one TX word for the 0.9/2.4 GHz FIFO.
// Latency : push pulses the cycle after the 4th synchronised strobe rise registers (about 4 clocks after the raw edge).
// Backpress: o_smi_write_req drops when the addressed FIFO is full; a word that still meets a full FIFO is dropped and flagged.
//
// Ports
//   i_sys_clk, i_reset_n            : only clock; synchronous active-low reset
//   i_ioc, i_data_in, o_data_out    : IOC register index, write data, registered read data
//   i_cs, i_fetch_cmd, i_load_cmd   : IOC select, read strobe, write strobe
//   o_fifo_09_push, o_fifo_24_push  : single-cycle push into the selected TX FIFO
//   o_fifo_pushed_data              : 32-bit word for either push (shared bus)
//   i_fifo_09_full, i_fifo_24_full  : TX FIFO full flags
//   i_smi_a, i_smi_swe_srw          : SMI address (bit 2 = channel) and asynchronous write strobe
//   i_smi_data_in                   : SMI write byte, stable while the strobe is high
//   o_smi_write_req                 : addressed channel can accept data
//
// IOC map: 0x00 version, 0x01 status {4'b0, busy, frame_err, ovf_24, ovf_09},
//          0x02 ctrl {7'b0, enable}; writing bit 1 of ctrl clears the sticky flags.

module smi_tx_ctrl #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  MODULE_VERSION = 8'h01
) (
    input  logic        i_sys_clk,
    input  logic        i_reset_n,
    input  logic [4:0]  i_ioc,
    input  logic [7:0]  i_data_in,
    output logic [7:0]  o_data_out,
    input  logic        i_cs,
    input  logic        i_fetch_cmd,
    input  logic        i_load_cmd,
    output logic        o_fifo_09_push,
    output logic        o_fifo_24_push,
    output logic [31:0] o_fifo_pushed_data,
    input  logic        i_fifo_09_full,
    input  logic        i_fifo_24_full,
    input  logic [2:0]  i_smi_a,
    input  logic        i_smi_swe_srw,
    input  logic [7:0]  i_smi_data_in,
    output logic        o_smi_write_req
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [4:0] IOC_VERSION = 5'h00;
    localparam logic [4:0] IOC_STATUS  = 5'h01;
    localparam logic [4:0] IOC_CTRL    = 5'h02;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUSH    = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        swe_sync;      // [0] first stage, [2] last stage
    logic [1:0]        byte_cnt;
    logic [23:0]       word_q;        // bytes already received, oldest in the upper bits
    logic              chan_q;        // 0 = 0.9 GHz, 1 = 2.4 GHz; latched at byte0
    logic [TO_W-1:0]   to_cnt;
    logic              enable_q;
    logic              ovf_09;
    logic              ovf_24;
    logic              frame_err;

    logic              rise;
    logic              ctrl_wr;
    logic              flag_clr;
    logic              sel_full;
    logic              chan_full;

    // Address bits [1:0] and the upper ctrl bits carry no meaning here.
    logic              unused_inputs;
    assign unused_inputs = ^{i_smi_a[1:0], i_data_in[7:2]};

    assign rise      = swe_sync[1] & ~swe_sync[2];
    assign ctrl_wr   = i_cs & i_load_cmd & (i_ioc == IOC_CTRL);
    assign flag_clr  = ctrl_wr & i_data_in[1];
    assign sel_full  = i_smi_a[2] ? i_fifo_24_full : i_fifo_09_full;
    assign chan_full = chan_q ? i_fifo_24_full : i_fifo_09_full;

    assign o_smi_write_req = i_reset_n & enable_q & ~sel_full;

    always_ff @(posedge i_sys_clk) begin
        if (!i_reset_n) begin
            state              <= ST_IDLE;
            swe_sync           <= 3'b000;
            byte_cnt           <= 2'd0;
            word_q             <= 24'h0;
            chan_q             <= 1'b0;
            to_cnt             <= '0;
            enable_q           <= 1'b0;
            ovf_09             <= 1'b0;
            ovf_24             <= 1'b0;
            frame_err          <= 1'b0;
            o_fifo_09_push     <= 1'b0;
            o_fifo_24_push     <= 1'b0;
            o_fifo_pushed_data <= 32'h0;
            o_data_out         <= 8'h0;
        end else begin
            swe_sync       <= {swe_sync[1:0], i_smi_swe_srw};
            o_fifo_09_push <= 1'b0;
            o_fifo_24_push <= 1'b0;

            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (enable_q && rise) begin
                        word_q   <= {16'h0, i_smi_data_in};
                        chan_q   <= i_smi_a[2];
                        byte_cnt <= 2'd1;
                        state    <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (!enable_q) begin
                        // Host disabled the link: quietly abandon the partial word.
                        state    <= ST_IDLE;
                        byte_cnt <= 2'd0;
                        to_cnt   <= '0;
                    end else if (rise) begin
                        to_cnt <= '0;
                        if (i_smi_a[2] != chan_q) begin
                            // Mid-word channel switch: restart with this byte as byte0.
                            frame_err <= 1'b1;
                            word_q    <= {16'h0, i_smi_data_in};
                            chan_q    <= i_smi_a[2];
                            byte_cnt  <= 2'd1;
                        end else if (byte_cnt == 2'd3) begin
                            state    <= ST_PUSH;
                            byte_cnt <= 2'd0;
                            if (chan_full) begin
                                if (chan_q) ovf_24 <= 1'b1;
                                else        ovf_09 <= 1'b1;
                            end else begin
                                o_fifo_pushed_data <= {word_q, i_smi_data_in};
                                if (chan_q) o_fifo_24_push <= 1'b1;
                                else        o_fifo_09_push <= 1'b1;
                            end
                        end else begin
                            word_q   <= {word_q[15:0], i_smi_data_in};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                        byte_cnt  <= 2'd0;
                        to_cnt    <= '0;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ST_PUSH: begin
                    // The push pulse is live during this cycle; strobe spacing
                    // guarantees no rise lands here.
                    state  <= ST_IDLE;
                    to_cnt <= '0;
                end

                default: begin
                    state    <= ST_IDLE;
                    byte_cnt <= 2'd0;
                end
            endcase

            if (ctrl_wr) begin
                enable_q <= i_data_in[0];
            end

            // Placed after the FSM so the clear overrides any same-cycle set.
            if (flag_clr) begin
                ovf_09    <= 1'b0;
                ovf_24    <= 1'b0;
                frame_err <= 1'b0;
            end

            if (i_cs && i_fetch_cmd) begin
                case (i_ioc)
                    IOC_VERSION: o_data_out <= MODULE_VERSION;
                    IOC_STATUS:  o_data_out <= {4'b0, (state != ST_IDLE), frame_err, ovf_24, ovf_09};
                    IOC_CTRL:    o_data_out <= {7'b0, enable_q};
                    default:     o_data_out <= o_data_out;
                endcase
            end
        end
    end

endmodule
